// File: rtl/stage_event_sequencer_if.sv
// Game-logic to transition-controller bundle for stage_event_sequencer.
// The game/physics side drives the master modport and the sequencer drives the slave modport.
interface stage_event_sequencer_if;
  logic        frame_tick;
  logic [9:0]  player_x;
  logic [8:0]  player_y;
  logic        player_dead;
  logic        goal_reached;
  logic        rstn_in;
  logic [1:0]  over;
  logic [9:0]  cx;
  logic [8:0]  cy;
  logic [2:0]  lives;
  logic        freeze;
  logic        game_over;
  logic [14:0] time_left;

  modport master (
    output frame_tick, player_x, player_y, player_dead, goal_reached, rstn_in,
    input  over, cx, cy, lives, freeze, game_over, time_left
  );

  modport slave (
    input  frame_tick, player_x, player_y, player_dead, goal_reached, rstn_in,
    output over, cx, cy, lives, freeze, game_over, time_left
  );
endinterface

// File: rtl/stage_event_sequencer.sv
// Turns death and goal events into iris-wipe requests, and tracks lives and game-over.
// Optional stage timer: define STAGE_TIMER_EN to build it; otherwise time_left is tied to 0.
module stage_event_sequencer #(
  parameter int unsigned LIVES_INIT   = 3,
  parameter int unsigned DEATH_FRAMES = 60,
  parameter int unsigned SPRITE_W     = 16,
  parameter int unsigned SPRITE_H     = 16,
  parameter int unsigned STAGE_FRAMES = 18000
) (
  input  logic                    clk,
  input  logic                    rst,
  stage_event_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_PLAY      = 3'd0,
    S_DYING     = 3'd1,
    S_WIPE      = 3'd2,
    S_RESYNC    = 3'd3,
    S_GAME_OVER = 3'd4
  } state_t;

  localparam logic [9:0]  CX_RST     = 10'd320;
  localparam logic [8:0]  CY_RST     = 9'd240;
  localparam logic [10:0] X_MAX      = 11'd639;
  localparam logic [9:0]  Y_MAX      = 10'd479;
  localparam logic [10:0] HALF_W     = 11'(SPRITE_W / 2);
  localparam logic [9:0]  HALF_H     = 10'(SPRITE_H / 2);
  localparam logic [2:0]  LIVES_RST  = 3'(LIVES_INIT);
  localparam logic [15:0] DEATH_LAST = 16'(DEATH_FRAMES - 1);

  function automatic logic [9:0] clamp_cx(input logic [9:0] x);
    logic [10:0] sum;
    sum = {1'b0, x} + HALF_W;
    return (sum > X_MAX) ? X_MAX[9:0] : sum[9:0];
  endfunction

  function automatic logic [8:0] clamp_cy(input logic [8:0] y);
    logic [9:0] sum;
    sum = {1'b0, y} + HALF_H;
    return (sum > Y_MAX) ? Y_MAX[8:0] : sum[8:0];
  endfunction

  state_t      r_state;
  logic [15:0] r_frame_cnt;
  logic [1:0]  r_over;
  logic [9:0]  r_cx;
  logic [8:0]  r_cy;
  logic [2:0]  r_lives;
  logic        r_freeze;
  logic        r_game_over;
  logic [9:0]  w_cx;
  logic [8:0]  w_cy;
  logic        w_expire;
  logic        w_death;

  assign w_cx = clamp_cx(bus.player_x);
  assign w_cy = clamp_cy(bus.player_y);

`ifdef STAGE_TIMER_EN
  localparam logic [14:0] TIME_RST = 15'(STAGE_FRAMES);
  logic [14:0] r_time_left;

  // Timer expiry is the frame tick that takes time_left from 1 to 0 during play.
  always_comb begin
    w_expire = 1'b0;
    if ((r_state == S_PLAY) && bus.frame_tick && (r_time_left == 15'd1)) begin
      w_expire = 1'b1;
    end else begin
      w_expire = 1'b0;
    end
  end

  // Stage timer: counts down only in PLAY, reloads when play resumes after a wipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_time_left <= TIME_RST;
    end else if ((r_state == S_PLAY) && bus.frame_tick && (r_time_left != 15'd0)) begin
      r_time_left <= r_time_left - 15'd1;
    end else if ((r_state == S_RESYNC) && bus.rstn_in && (r_lives != 3'd0)) begin
      r_time_left <= TIME_RST;
    end else begin
      r_time_left <= r_time_left;
    end
  end

  assign bus.time_left = r_time_left;
`else
  logic [14:0] w_unused_stage;
  assign w_unused_stage = 15'(STAGE_FRAMES);
  assign w_expire       = 1'b0;
  assign bus.time_left  = 15'd0;
`endif

  assign w_death = bus.player_dead | w_expire;

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_PLAY;
      r_frame_cnt <= 16'd0;
      r_over      <= 2'b00;
      r_cx        <= CX_RST;
      r_cy        <= CY_RST;
      r_lives     <= LIVES_RST;
      r_freeze    <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      case (r_state)
        S_PLAY: begin
          // Death (or timer expiry) takes priority over a same-cycle goal.
          if (w_death) begin
            r_state     <= S_DYING;
            r_frame_cnt <= 16'd0;
            r_lives     <= (r_lives == 3'd0) ? 3'd0 : (r_lives - 3'd1);
            r_freeze    <= 1'b1;
            r_cx        <= w_cx;
            r_cy        <= w_cy;
          end else if (bus.goal_reached) begin
            r_state  <= S_WIPE;
            r_over   <= 2'b11;
            r_freeze <= 1'b1;
            r_cx     <= w_cx;
            r_cy     <= w_cy;
          end else begin
            r_freeze <= 1'b0;
          end
        end
        S_DYING: begin
          if (bus.frame_tick) begin
            if (r_frame_cnt == DEATH_LAST) begin
              r_state <= S_WIPE;
              r_over  <= 2'b10;
            end else begin
              r_frame_cnt <= r_frame_cnt + 16'd1;
            end
          end
        end
        S_WIPE: begin
          if (!bus.rstn_in) begin
            r_state <= S_RESYNC;
            r_over  <= 2'b00;
          end
        end
        S_RESYNC: begin
          if (bus.rstn_in) begin
            if (r_lives == 3'd0) begin
              r_state     <= S_GAME_OVER;
              r_game_over <= 1'b1;
            end else begin
              r_state  <= S_PLAY;
              r_freeze <= 1'b0;
            end
          end
        end
        S_GAME_OVER: begin
          r_over      <= 2'b00;
          r_freeze    <= 1'b1;
          r_game_over <= 1'b1;
        end
        default: begin
          r_state  <= S_PLAY;
          r_over   <= 2'b00;
          r_freeze <= 1'b0;
        end
      endcase
    end
  end

  assign bus.over      = r_over;
  assign bus.cx        = r_cx;
  assign bus.cy        = r_cy;
  assign bus.lives     = r_lives;
  assign bus.freeze    = r_freeze;
  assign bus.game_over = r_game_over;

endmodule

// File: tb/tb_stage_event_sequencer.sv
// Directed bench for stage_event_sequencer with a phase-level reference model checked every cycle.
module tb_stage_event_sequencer;
  localparam int LIVES   = 3;
  localparam int DFRAMES = 60;
  localparam int SW      = 16;
  localparam int SH      = 16;
  localparam int STAGE   = 5;

  localparam int P_PLAY = 0, P_DYING = 1, P_WIPE = 2, P_RESYNC = 3, P_OVER = 4;

  logic clk;
  logic rst;
  stage_event_sequencer_if bus_if ();

  stage_event_sequencer #(
    .LIVES_INIT(LIVES), .DEATH_FRAMES(DFRAMES), .SPRITE_W(SW), .SPRITE_H(SH), .STAGE_FRAMES(STAGE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: game phase, lives, wipe request and centre, in plain integers.
  int m_phase, m_lives, m_over, m_cx, m_cy, m_time, m_ticks;

  task automatic model_step();
    int expire;
    if (rst) begin
      m_phase = P_PLAY; m_lives = LIVES; m_over = 0; m_cx = 320; m_cy = 240; m_ticks = 0;
`ifdef STAGE_TIMER_EN
      m_time = STAGE;
`else
      m_time = 0;
`endif
    end else begin
      case (m_phase)
        P_PLAY: begin
          expire = 0;
`ifdef STAGE_TIMER_EN
          if (bus_if.frame_tick && m_time > 0) begin
            m_time = m_time - 1;
            if (m_time == 0) expire = 1;
          end
`endif
          if (bus_if.player_dead || expire != 0) begin
            m_phase = P_DYING; m_ticks = 0;
            m_lives = (m_lives > 0) ? m_lives - 1 : 0;
            m_cx = (int'(bus_if.player_x) + SW / 2 > 639) ? 639 : int'(bus_if.player_x) + SW / 2;
            m_cy = (int'(bus_if.player_y) + SH / 2 > 479) ? 479 : int'(bus_if.player_y) + SH / 2;
          end else if (bus_if.goal_reached) begin
            m_phase = P_WIPE; m_over = 3;
            m_cx = (int'(bus_if.player_x) + SW / 2 > 639) ? 639 : int'(bus_if.player_x) + SW / 2;
            m_cy = (int'(bus_if.player_y) + SH / 2 > 479) ? 479 : int'(bus_if.player_y) + SH / 2;
          end
        end
        P_DYING: if (bus_if.frame_tick) begin
          m_ticks = m_ticks + 1;
          if (m_ticks == DFRAMES) begin m_phase = P_WIPE; m_over = 2; end
        end
        P_WIPE: if (!bus_if.rstn_in) begin m_phase = P_RESYNC; m_over = 0; end
        P_RESYNC: if (bus_if.rstn_in) begin
          if (m_lives == 0) m_phase = P_OVER;
          else begin
            m_phase = P_PLAY;
`ifdef STAGE_TIMER_EN
            m_time = STAGE;
`endif
          end
        end
        default: m_over = 0;
      endcase
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    check("over",      int'(bus_if.over),      m_over);
    check("cx",        int'(bus_if.cx),        m_cx);
    check("cy",        int'(bus_if.cy),        m_cy);
    check("lives",     int'(bus_if.lives),     m_lives);
    check("freeze",    int'(bus_if.freeze),    (m_phase != P_PLAY) ? 1 : 0);
    check("game_over", int'(bus_if.game_over), (m_phase == P_OVER) ? 1 : 0);
    check("time_left", int'(bus_if.time_left), m_time);
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); bus_if.frame_tick = 1'b1;
      @(negedge clk); bus_if.frame_tick = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic pulse(input int dead, input int goal, input int x, input int y);
    @(negedge clk);
    bus_if.player_dead  = (dead != 0);
    bus_if.goal_reached = (goal != 0);
    bus_if.player_x     = 10'(x);
    bus_if.player_y     = 9'(y);
    @(negedge clk);
    bus_if.player_dead  = 1'b0;
    bus_if.goal_reached = 1'b0;
  endtask

  task automatic wipe_done();
    @(negedge clk); bus_if.rstn_in = 1'b0;
    @(negedge clk);
    check("over_cleared", int'(bus_if.over), 0);
    cycles(3);
    bus_if.rstn_in = 1'b1;
    cycles(2);
  endtask

  initial begin
    rst = 1'b1;
    bus_if.frame_tick = 1'b0; bus_if.player_x = 10'd0; bus_if.player_y = 9'd0;
    bus_if.player_dead = 1'b0; bus_if.goal_reached = 1'b0; bus_if.rstn_in = 1'b1;
    cycles(3);
    rst = 1'b0;
    cycles(1);
    check("rst_over", int'(bus_if.over), 0);
    check("rst_lives", int'(bus_if.lives), 3);
    check("rst_cx", int'(bus_if.cx), 320);
    check("rst_cy", int'(bus_if.cy), 240);

    // Power-up wipe: rstn_in low during PLAY is ignored.
    bus_if.rstn_in = 1'b0; cycles(8); bus_if.rstn_in = 1'b1; cycles(1);
    check("pwr_over", int'(bus_if.over), 0);
    check("pwr_freeze", int'(bus_if.freeze), 0);
    check("pwr_lives", int'(bus_if.lives), 3);

    pulse(0, 1, 100, 200);
    check("goal_over", int'(bus_if.over), 3);
    check("goal_cx", int'(bus_if.cx), 108);
    check("goal_cy", int'(bus_if.cy), 208);
    check("goal_lives", int'(bus_if.lives), 3);
    cycles(4);
    check("goal_over_hold", int'(bus_if.over), 3);
    wipe_done();
    check("goal_play_freeze", int'(bus_if.freeze), 0);

    pulse(1, 0, 636, 475);
    check("die_lives", int'(bus_if.lives), 2);
    check("die_freeze", int'(bus_if.freeze), 1);
    check("die_cx", int'(bus_if.cx), 639);
    check("die_cy", int'(bus_if.cy), 479);
    frames(59);
    check("die_over_59", int'(bus_if.over), 0);
    frames(1);
    check("die_over_60", int'(bus_if.over), 2);
    wipe_done();

    pulse(1, 1, 10, 20);
    check("both_lives", int'(bus_if.lives), 1);
    check("both_over_0", int'(bus_if.over), 0);
    frames(60);
    check("both_over_60", int'(bus_if.over), 2);
    wipe_done();

    pulse(1, 0, 300, 100);
    check("last_lives", int'(bus_if.lives), 0);
    frames(60);
    wipe_done();
    check("go_flag", int'(bus_if.game_over), 1);
    check("go_lives", int'(bus_if.lives), 0);
    pulse(1, 0, 50, 50);
    pulse(0, 1, 60, 60);
    cycles(2);
    check("go_ignore_over", int'(bus_if.over), 0);
    check("go_ignore_cx", int'(bus_if.cx), 308);
    check("go_still", int'(bus_if.game_over), 1);

    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    cycles(1);
    check("rerst_lives", int'(bus_if.lives), 3);
    check("rerst_go", int'(bus_if.game_over), 0);

`ifdef STAGE_TIMER_EN
    check("tmr_start", int'(bus_if.time_left), 5);
    frames(5);
    check("tmr_zero", int'(bus_if.time_left), 0);
    check("tmr_lives", int'(bus_if.lives), 2);
    check("tmr_freeze", int'(bus_if.freeze), 1);
    frames(60);
    wipe_done();
    check("tmr_reload", int'(bus_if.time_left), 5);
`else
    check("tmr_off", int'(bus_if.time_left), 0);
`endif

    cycles(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
